add_sub_pipe: RTL
=================

Name: add_sub_pipe

Overview:
Parametrised, registered successor to the 4-bit combinational add/subtract unit.
- Adds or subtracts WIDTH-bit operands with a one-entry valid/ready output register.
- Optional accumulator mode: the A operand is replaced by the previous result.
- Drives carry, signed-overflow, zero and negative flags.
- Drives a time-multiplexed hex seven-segment display of the last result for the board LCD/segment header.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SCAN_DIV, 1024, clk cycles each display digit is held (>=2).
- NDIG, localparam (WIDTH+3)/4, number of hex digits scanned.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept the request this cycle.
- a  in  WIDTH  operand A, ignored when acc_mode=1.
- b  in  WIDTH  operand B.
- sub  in  1  0 = add, 1 = subtract.
- acc_mode  in  1  1 = use accumulator instead of a.
- clr_acc  in  1  synchronous accumulator clear.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- result  out  WIDTH  registered sum/difference.
- carry  out  1  carry out; for subtract, 1 = no borrow.
- ov  out  1  two's-complement overflow.
- zero  out  1  result == 0.
- neg  out  1  result MSB.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- an  out  NDIG  one-hot digit enable, active-high; bit 0 = least significant nibble.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0; result, carry, ov, zero, neg = 0; accumulator=0.
  - Scan divider=0, digit index=0, an=1, seg=7'b0111111 (digit "0").
  - Reset mid-operation discards any pending result with no output pulse.
- in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
- Accept:
  - Occurs when in_valid && in_ready.
  - x = acc_mode ? acc_eff : a, where acc_eff = clr_acc ? 0 : acc (clear takes effect before the operand is read).
  - Computed over WIDTH+1 bits: {carry, result} = x + (sub ? ~b : b) + sub.
  - ov = (x[MSB] == bb[MSB]) && (result[MSB] != x[MSB]), where bb = sub ? ~b : b.
  - zero and neg are derived from the new result.
  - All outputs register on the accept edge, so out_valid rises 1 cycle after accept (latency 1).
  - Accumulator loads the new result on every accept, in either mode.
- clr_acc without an accept: accumulator <= 0; the result register is unchanged.
- Hold: while out_valid && !out_ready, result and flags are stable and in_ready=0.
- Consume:
  - out_valid && out_ready with no new accept: out_valid <= 0.
  - Result and flags keep their last value (the display keeps showing it).
  - Consume and accept in the same cycle: out_valid stays 1 and the new result replaces the old.
- Width: nibble k of result feeds digit k. A top nibble narrower than 4 bits is zero-extended.
- Display scan:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index increments modulo NDIG (NDIG-1 -> 0).
  - an = one-hot(index); seg = hex encoding of the selected nibble, registered (1-cycle lag after an index change is acceptable and expected).
  - Hex set 0-9, A, b, C, d, E, F, using standard 7-seg encodings.
- No other state. Inputs are sampled only on accept.

Decomposition:
- Shared package add_sub_pkg:
  - Segment constants SEG_0..SEG_F.
  - Function hex_to_seg (4-bit in, 7-bit out).
  - Op encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module seg7_scan (params NDIG, SCAN_DIV):
  - Owns the divider, digit index, an and seg.
  - Input: NDIG*4-bit value.
  - Shares clk and rst_n.
- Arithmetic and handshake stay in add_sub_pipe.

Test Plan:
- WIDTH=4, out_ready=1: a=5, b=4, sub=0 -> next cycle result=9, carry=0, ov=1, neg=1, zero=0, out_valid=1.
- WIDTH=4: a=5, b=1, sub=1 -> result=4, carry=1, ov=0. Then a=9, b=8, sub=1 -> result=1, carry=1, ov=0. Then a=1, b=1, sub=1 -> result=0, zero=1, carry=1.
- WIDTH=8, out_ready=0: accept a=0x10, b=0x01 (add) -> result=0x11, in_ready=0. Hold in_valid with a=0x20 for 5 cycles -> result stays 0x11. Raise out_ready -> next cycle result=0x21, no lost or duplicated result.
- WIDTH=8, acc_mode=1, clr_acc=1 with b=3 add -> result=3. Then b=3 add twice -> 6, 9. Then b=10 sub -> 0xFF, carry=0, neg=1.
- Reset: rst_n=0 for 1 cycle mid-hold -> out_valid=0, result=0, acc=0, an=1, seg=7'b0111111 on the next edge.
- WIDTH=8, SCAN_DIV=4: result=0xA5 -> an toggles 01->10->01 every 4 cycles; seg shows "5" (7'b1101101) with an=01 and "A" (7'b1110111) with an=10.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared constants and helpers for the add/subtract pipeline and its hex display.
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_0;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed hex display driver: one digit enabled per SCAN_DIV clocks.
module seg7_scan
  import add_sub_pkg::*;
#(
  parameter int unsigned NDIG     = 2,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG*4-1:0] value,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          wrap;

  // Digit index advances once per divider wrap
  always_comb begin
    wrap    = (div == DW'(SCAN_DIV - 1));
    idx_nxt = idx;
    if (wrap) begin
      idx_nxt = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
    end
  end

  // seg follows the enabled digit; it picks up a new value one cycle after it changes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
      an  <= NDIG'(1);
      seg <= SEG_0;
    end else begin
      div <= wrap ? '0 : div + DW'(1);
      idx <= idx_nxt;
      an  <= NDIG'(1) << idx_nxt;
      seg <= hex_to_seg(value[4*idx_nxt +: 4]);
    end
  end

endmodule

// File: rtl/add_sub_pipe.sv
// Registered add/subtract unit with accumulator mode, status flags and hex display.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned SCAN_DIV = 1024,
  localparam int unsigned NDIG     = (WIDTH + 3) / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc_mode,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ov,
  output logic             zero,
  output logic             neg,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum_r;
  logic             sum_c;
  logic             ov_c;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Subtract is x + ~b + 1; a clear in the same cycle zeroes the accumulator operand
  always_comb begin
    acc_eff        = clr_acc ? '0 : acc;
    x              = acc_mode ? acc_eff : a;
    bb             = (sub == OP_SUB) ? ~b : b;
    {sum_c, sum_r} = {1'b0, x} + {1'b0, bb} + (WIDTH + 1)'(sub == OP_SUB);
    ov_c           = (x[WIDTH-1] == bb[WIDTH-1]) && (sum_r[WIDTH-1] != x[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ov        <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= sum_r;
      carry     <= sum_c;
      ov        <= ov_c;
      zero      <= (sum_r == '0);
      neg       <= sum_r[WIDTH-1];
      acc       <= sum_r;
    end else begin
      if (clr_acc) acc <= '0;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

  seg7_scan #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .value ((4 * NDIG)'(result)),
    .an    (an),
    .seg   (seg)
  );

endmodule
